// File: rtl/sequence_control_ext.sv
// Sequence controller: decodes IR into datapath strobes, with a memory handshake timeout,
// a depth-tracked return stack, illegal-opcode trapping and a Run pause at fetch.
// state | meaning: RESET pc reset | FETCH instr read | LOADIR ir load | DECODE issue
//       MWAIT data access | EXEC writeback | HALT stopped | FAULT trapped
module sequence_control_ext #(
  parameter int DataWidth    = 16,
  parameter int RegAddrWidth = 3,
  parameter int StackDepth   = 4,
  parameter int WaitLimit    = 15
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [DataWidth-1:0]    IR,
  input  logic [3:0]              ALU_FlgsIn,
  input  logic                    Mem_Rdy,
  input  logic                    Run,
  output logic                    IR_Ld,
  output logic                    PC_Ld,
  output logic                    PC_Rst,
  output logic                    PC_Inc,
  output logic                    MEM_En,
  output logic                    MEM_Wr,
  output logic                    REG_WE,
  output logic                    ALU_Ld,
  output logic                    FLG_Ld,
  output logic                    FLG_Rst,
  output logic                    STK_Push,
  output logic                    STK_Pop,
  output logic                    BRA_Src,
  output logic                    Src1_Sel,
  output logic [1:0]              PC_Src,
  output logic [1:0]              ADDR_Src,
  output logic [1:0]              DATA_Src,
  output logic [RegAddrWidth-1:0] REG_Dest,
  output logic [RegAddrWidth-1:0] REG_Src1,
  output logic [RegAddrWidth-1:0] REG_Src2,
  output logic [3:0]              ALU_Op,
  output logic                    Halt,
  output logic                    Fault,
  output logic [1:0]              Fault_Code,
  output logic [3:0]              Stk_Depth
);

  localparam int WW = (WaitLimit < 2) ? 1 : $clog2(WaitLimit + 1);

  localparam logic [3:0] OP_NOP = 4'd0,  OP_LDI = 4'd1,  OP_LD  = 4'd2,  OP_ST  = 4'd3;
  localparam logic [3:0] OP_STX = 4'd4,  OP_JPL = 4'd5,  OP_RET = 4'd6,  OP_BRD = 4'd7;
  localparam logic [3:0] OP_BRX = 4'd8,  OP_ADD = 4'd9,  OP_SUB = 4'd10, OP_AND = 4'd11;
  localparam logic [3:0] OP_OR  = 4'd12, OP_XOR = 4'd13, OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_LOADIR, S_DECODE, S_MWAIT, S_EXEC, S_HALT, S_FAULT
  } state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic [3:0]      depth, depth_nxt;
  logic [1:0]      code, code_nxt;
  logic [3:0]      opcode;
  logic [1:0]      cn;
  logic            link_n, br_taken, wait_hit;
  logic            unused_ir;

  assign opcode    = IR[DataWidth-1 -: 4];
  assign link_n    = IR[DataWidth-5];
  assign cn        = IR[DataWidth-5 -: 2];
  assign wait_hit  = (wait_cnt == WW'(WaitLimit));
  assign unused_ir = ^IR;

  assign REG_Dest   = IR[DataWidth-5 -: RegAddrWidth];
  assign REG_Src1   = IR[4 +: RegAddrWidth];
  assign REG_Src2   = IR[RegAddrWidth-1:0];
  assign Fault_Code = code;
  assign Stk_Depth  = depth;

  // flags are {V,N,C,Z}
  always_comb begin
    case (cn)
      2'd0:    br_taken = ALU_FlgsIn[0];
      2'd1:    br_taken = !ALU_FlgsIn[0];
      2'd2:    br_taken = ALU_FlgsIn[2] ^ ALU_FlgsIn[3];
      default: br_taken = ALU_FlgsIn[1];
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_RESET;
      wait_cnt <= '0;
      depth    <= '0;
      code     <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      depth    <= depth_nxt;
      code     <= code_nxt;
    end
  end

  always_comb begin
    IR_Ld = 1'b0; PC_Ld = 1'b0; PC_Rst = 1'b0; PC_Inc = 1'b0;
    MEM_En = 1'b0; MEM_Wr = 1'b0; REG_WE = 1'b0; ALU_Ld = 1'b0;
    FLG_Ld = 1'b0; FLG_Rst = 1'b0; STK_Push = 1'b0; STK_Pop = 1'b0;
    BRA_Src = 1'b0; Src1_Sel = 1'b0; PC_Src = 2'd0; ADDR_Src = 2'd0;
    DATA_Src = 2'd0; ALU_Op = 4'd0; Halt = 1'b0; Fault = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    depth_nxt = depth;
    code_nxt  = code;
    case (state)
      S_RESET: begin
        PC_Rst    = 1'b1;
        wait_nxt  = '0;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (!Run) begin
          wait_nxt = '0;
        end else begin
          MEM_En = 1'b1;
          if (Mem_Rdy) begin
            wait_nxt  = '0;
            state_nxt = S_LOADIR;
          end else if (wait_hit) begin
            wait_nxt  = '0;
            code_nxt  = 2'd3;
            state_nxt = S_FAULT;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end
      end
      S_LOADIR: begin
        IR_Ld     = 1'b1;
        PC_Inc    = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = S_FETCH;
        case (opcode)
          OP_NOP: ;
          OP_LDI: REG_WE = 1'b1;
          OP_LD: begin
            MEM_En    = 1'b1;
            ADDR_Src  = 2'd2;
            state_nxt = S_MWAIT;
          end
          OP_ST, OP_STX: begin
            MEM_En    = 1'b1;
            MEM_Wr    = 1'b1;
            ADDR_Src  = 2'd2;
            Src1_Sel  = (opcode == OP_STX);
            state_nxt = S_MWAIT;
          end
          OP_JPL: begin
            if (!link_n && depth == 4'(StackDepth)) begin
              code_nxt  = 2'd1;
              state_nxt = S_FAULT;
            end else begin
              PC_Ld    = 1'b1;
              PC_Src   = 2'd2;
              Src1_Sel = 1'b1;
              if (!link_n) begin
                STK_Push  = 1'b1;
                depth_nxt = depth + 4'd1;
              end
            end
          end
          OP_RET: begin
            if (depth == 4'd0) begin
              code_nxt  = 2'd2;
              state_nxt = S_FAULT;
            end else begin
              PC_Ld     = 1'b1;
              PC_Src    = 2'd1;
              STK_Pop   = 1'b1;
              depth_nxt = depth - 4'd1;
            end
          end
          OP_BRD, OP_BRX: begin
            FLG_Rst = 1'b1;
            if (br_taken) begin
              PC_Ld    = 1'b1;
              BRA_Src  = (opcode == OP_BRD);
              Src1_Sel = (opcode == OP_BRX);
            end
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ALU_Op    = opcode - 4'd9;
            Src1_Sel  = 1'b1;
            ALU_Ld    = 1'b1;
            FLG_Ld    = 1'b1;
            state_nxt = S_EXEC;
          end
          OP_HLT: state_nxt = S_HALT;
          default: begin
            code_nxt  = 2'd0;
            state_nxt = S_FAULT;
          end
        endcase
      end
      S_MWAIT: begin
        MEM_En   = 1'b1;
        MEM_Wr   = (opcode != OP_LD);
        ADDR_Src = 2'd2;
        Src1_Sel = (opcode == OP_STX);
        if (Mem_Rdy) begin
          wait_nxt  = '0;
          state_nxt = (opcode == OP_LD) ? S_EXEC : S_FETCH;
        end else if (wait_hit) begin
          wait_nxt  = '0;
          code_nxt  = 2'd3;
          state_nxt = S_FAULT;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      S_EXEC: begin
        REG_WE = 1'b1;
        if (opcode == OP_LD) begin
          DATA_Src = 2'd1;
        end else begin
          DATA_Src = 2'd2;
          ALU_Op   = opcode - 4'd9;
        end
        state_nxt = S_FETCH;
      end
      S_HALT:  Halt  = 1'b1;
      S_FAULT: Fault = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sequence_control_ext.sv
// Scoreboard bench for sequence_control_ext: each cycle's expected output vector is queued
// when the stimulus is driven and compared against the DUT at the falling edge.
module tb_sequence_control_ext;
  localparam int DW = 16, RAW = 3, SD = 4, WL = 15;

  logic Clk = 1'b0, Reset = 1'b1;
  logic [DW-1:0] IR = '0;
  logic [3:0] ALU_FlgsIn = '0;
  logic Mem_Rdy = 1'b0, Run = 1'b0;
  logic IR_Ld, PC_Ld, PC_Rst, PC_Inc, MEM_En, MEM_Wr, REG_WE, ALU_Ld, FLG_Ld, FLG_Rst;
  logic STK_Push, STK_Pop, BRA_Src, Src1_Sel, Halt, Fault;
  logic [1:0] PC_Src, ADDR_Src, DATA_Src, Fault_Code;
  logic [RAW-1:0] REG_Dest, REG_Src1, REG_Src2;
  logic [3:0] ALU_Op, Stk_Depth;

  sequence_control_ext #(.DataWidth(DW), .RegAddrWidth(RAW), .StackDepth(SD), .WaitLimit(WL)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .ALU_FlgsIn(ALU_FlgsIn), .Mem_Rdy(Mem_Rdy), .Run(Run),
    .IR_Ld(IR_Ld), .PC_Ld(PC_Ld), .PC_Rst(PC_Rst), .PC_Inc(PC_Inc), .MEM_En(MEM_En),
    .MEM_Wr(MEM_Wr), .REG_WE(REG_WE), .ALU_Ld(ALU_Ld), .FLG_Ld(FLG_Ld), .FLG_Rst(FLG_Rst),
    .STK_Push(STK_Push), .STK_Pop(STK_Pop), .BRA_Src(BRA_Src), .Src1_Sel(Src1_Sel),
    .PC_Src(PC_Src), .ADDR_Src(ADDR_Src), .DATA_Src(DATA_Src), .REG_Dest(REG_Dest),
    .REG_Src1(REG_Src1), .REG_Src2(REG_Src2), .ALU_Op(ALU_Op), .Halt(Halt), .Fault(Fault),
    .Fault_Code(Fault_Code), .Stk_Depth(Stk_Depth)
  );

  always #5 Clk = ~Clk;

  localparam logic [31:0] IRLD = 32'h8000_0000, PCLD = 32'h4000_0000, PCRST = 32'h2000_0000;
  localparam logic [31:0] PCINC = 32'h1000_0000, MEMEN = 32'h0800_0000, MEMWR = 32'h0400_0000;
  localparam logic [31:0] REGWE = 32'h0200_0000, ALULD = 32'h0100_0000, FLGLD = 32'h0080_0000;
  localparam logic [31:0] FLGRST = 32'h0040_0000, PUSH = 32'h0020_0000, POP = 32'h0010_0000;
  localparam logic [31:0] BRA = 32'h0008_0000, S1SEL = 32'h0004_0000;
  localparam logic [31:0] HLT = 32'h0000_0080, FLT = 32'h0000_0040, NONE = 32'h0;

  function automatic logic [31:0] pcs(int v);  return 32'(v) << 16; endfunction
  function automatic logic [31:0] adr(int v);  return 32'(v) << 14; endfunction
  function automatic logic [31:0] dsrc(int v); return 32'(v) << 12; endfunction
  function automatic logic [31:0] aop(int v);  return 32'(v) << 8;  endfunction

  typedef struct { string tag; logic [40:0] exp; } sb_t;
  sb_t sb_q[$];
  int n_checks = 0, n_fail = 0;
  int m_depth = 0;
  logic [1:0] m_code = 2'd0;

  function automatic logic [40:0] obs();
    return {IR_Ld, PC_Ld, PC_Rst, PC_Inc, MEM_En, MEM_Wr, REG_WE, ALU_Ld, FLG_Ld, FLG_Rst,
            STK_Push, STK_Pop, BRA_Src, Src1_Sel, PC_Src, ADDR_Src, DATA_Src, ALU_Op,
            Halt, Fault, Fault_Code, Stk_Depth, REG_Dest, REG_Src1, REG_Src2};
  endfunction

  function automatic logic [40:0] ev(logic [31:0] s, logic [15:0] ir);
    logic [31:0] t;
    t = s | {26'd0, m_code, 4'(m_depth)};
    return {t, ir[11:9], ir[6:4], ir[2:0]};
  endfunction

  task automatic chk(string tag, logic [40:0] got, logic [40:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
  task automatic step(string tag, logic [15:0] ir, logic rdy, logic run, logic [3:0] flg,
                      logic [31:0] s);
    sb_t e;
    IR = ir; Mem_Rdy = rdy; Run = run; ALU_FlgsIn = flg;
    e.tag = tag;
    e.exp = ev(s, ir);
    sb_q.push_back(e);
    @(negedge Clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs(), e.exp);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    m_depth = 0;
    m_code = 2'd0;
    @(posedge Clk);
    #1;
    step("rst_hold", 16'h0, 1'b1, 1'b1, 4'h0, PCRST);
    Reset = 1'b0;
    step("rst_rel", 16'h0, 1'b1, 1'b1, 4'h0, PCRST);
  endtask

  task automatic fl(logic [15:0] ir);
    step("fetch", ir, 1'b1, 1'b1, 4'h0, MEMEN);
    step("loadir", ir, 1'b1, 1'b1, 4'h0, IRLD | PCINC);
  endtask

  typedef struct { logic [15:0] ir; logic [3:0] flg; logic [31:0] s; } br_t;
  br_t br_tab[6];

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    br_tab[0] = '{16'h7800, 4'b0100, PCLD | BRA | FLGRST};
    br_tab[1] = '{16'h7800, 4'b1100, FLGRST};
    br_tab[2] = '{16'h8000, 4'b0001, PCLD | S1SEL | FLGRST};
    br_tab[3] = '{16'h8400, 4'b0001, FLGRST};
    br_tab[4] = '{16'h7C00, 4'b0010, PCLD | BRA | FLGRST};
    br_tab[5] = '{16'h7400, 4'b0000, PCLD | BRA | FLGRST};

    do_reset();
    for (int i = 0; i < 3; i++) begin
      fl(16'h0000);
      step("nop_dec", 16'h0000, 1'b1, 1'b1, 4'h0, NONE);
    end

    fl(16'h1234);
    step("ldi_dec", 16'h1234, 1'b1, 1'b1, 4'h0, REGWE);

    fl(16'h2205);
    step("ld_dec", 16'h2205, 1'b0, 1'b1, 4'h0, MEMEN | adr(2));
    for (int i = 0; i < 3; i++) step("ld_wait", 16'h2205, 1'b0, 1'b1, 4'h0, MEMEN | adr(2));
    step("ld_rdy", 16'h2205, 1'b1, 1'b1, 4'h0, MEMEN | adr(2));
    step("ld_exec", 16'h2205, 1'b1, 1'b1, 4'h0, REGWE | dsrc(1));

    fl(16'h3312);
    step("st_dec", 16'h3312, 1'b1, 1'b1, 4'h0, MEMEN | MEMWR | adr(2));
    step("st_wait", 16'h3312, 1'b1, 1'b1, 4'h0, MEMEN | MEMWR | adr(2));
    fl(16'h4456);
    step("stx_dec", 16'h4456, 1'b1, 1'b1, 4'h0, MEMEN | MEMWR | adr(2) | S1SEL);
    step("stx_wait", 16'h4456, 1'b1, 1'b1, 4'h0, MEMEN | MEMWR | adr(2) | S1SEL);

    fl(16'hA123);
    step("sub_dec", 16'hA123, 1'b1, 1'b1, 4'h0, aop(1) | S1SEL | ALULD | FLGLD);
    step("sub_exec", 16'hA123, 1'b1, 1'b1, 4'h0, REGWE | dsrc(2) | aop(1));
    fl(16'hD0F7);
    step("xor_dec", 16'hD0F7, 1'b1, 1'b1, 4'h0, aop(4) | S1SEL | ALULD | FLGLD);
    step("xor_exec", 16'hD0F7, 1'b1, 1'b1, 4'h0, REGWE | dsrc(2) | aop(4));

    foreach (br_tab[i]) begin
      fl(br_tab[i].ir);
      step("br_dec", br_tab[i].ir, 1'b1, 1'b1, br_tab[i].flg, br_tab[i].s);
    end

    // Run=0 in FETCH must also clear the wait counter
    for (int i = 0; i < 10; i++) step("run_wait", 16'h0, 1'b0, 1'b1, 4'h0, MEMEN);
    for (int i = 0; i < 8; i++) step("run_pause", 16'h0, 1'b0, 1'b0, 4'h0, NONE);
    for (int i = 0; i < WL; i++) step("run_resume", 16'h0, 1'b0, 1'b1, 4'h0, MEMEN);
    step("run_rdy", 16'h0, 1'b1, 1'b1, 4'h0, MEMEN);
    step("run_loadir", 16'h0, 1'b1, 1'b1, 4'h0, IRLD | PCINC);
    step("run_dec", 16'h0, 1'b1, 1'b1, 4'h0, NONE);

    fl(16'hA123);
    step("sub_dec_r0", 16'hA123, 1'b1, 1'b0, 4'h0, aop(1) | S1SEL | ALULD | FLGLD);
    step("sub_exec_r0", 16'hA123, 1'b1, 1'b0, 4'h0, REGWE | dsrc(2) | aop(1));
    for (int i = 0; i < 3; i++) step("pause_fetch", 16'hA123, 1'b1, 1'b0, 4'h0, NONE);

    fl(16'h5800);
    step("jmp_dec", 16'h5800, 1'b1, 1'b1, 4'h0, PCLD | pcs(2) | S1SEL);
    for (int i = 0; i < SD; i++) begin
      fl(16'h5000);
      step("jpl_dec", 16'h5000, 1'b1, 1'b1, 4'h0, PCLD | pcs(2) | S1SEL | PUSH);
      m_depth++;
    end
    fl(16'h6000);
    step("ret_dec", 16'h6000, 1'b1, 1'b1, 4'h0, PCLD | pcs(1) | POP);
    m_depth--;
    fl(16'h5000);
    step("jpl_dec", 16'h5000, 1'b1, 1'b1, 4'h0, PCLD | pcs(2) | S1SEL | PUSH);
    m_depth++;
    fl(16'h5000);
    step("jpl_ovf_dec", 16'h5000, 1'b1, 1'b1, 4'h0, NONE);
    m_code = 2'd1;
    for (int i = 0; i < 3; i++) step("fault_ovf", 16'h5000, 1'b1, 1'b1, 4'h0, FLT);

    do_reset();
    for (int i = 0; i < 2; i++) begin
      fl(16'h5000);
      step("jpl_dec", 16'h5000, 1'b1, 1'b1, 4'h0, PCLD | pcs(2) | S1SEL | PUSH);
      m_depth++;
    end
    fl(16'h2205);
    step("ld_dec", 16'h2205, 1'b0, 1'b1, 4'h0, MEMEN | adr(2));
    step("ld_wait", 16'h2205, 1'b0, 1'b1, 4'h0, MEMEN | adr(2));
    Reset = 1'b1;
    m_depth = 0;
    step("rst_mid", 16'h2205, 1'b1, 1'b1, 4'h0, PCRST);
    Reset = 1'b0;
    step("rst_mid_rel", 16'h2205, 1'b1, 1'b1, 4'h0, PCRST);

    fl(16'h6000);
    step("ret_unf_dec", 16'h6000, 1'b1, 1'b1, 4'h0, NONE);
    m_code = 2'd2;
    for (int i = 0; i < 2; i++) step("fault_unf", 16'h6000, 1'b1, 1'b1, 4'h0, FLT);

    do_reset();
    fl(16'hE000);
    step("ill_dec", 16'hE000, 1'b1, 1'b1, 4'h0, NONE);
    m_code = 2'd0;
    for (int i = 0; i < 2; i++) step("fault_ill", 16'hE000, 1'b1, 1'b1, 4'h0, FLT);

    do_reset();
    for (int i = 0; i <= WL; i++) step("to_fetch", 16'h0, 1'b0, 1'b1, 4'h0, MEMEN);
    m_code = 2'd3;
    for (int i = 0; i < 3; i++) step("fault_to", 16'h0, 1'b1, 1'b1, 4'h0, FLT);

    do_reset();
    for (int i = 0; i < WL; i++) step("lim_fetch", 16'h0, 1'b0, 1'b1, 4'h0, MEMEN);
    step("lim_rdy", 16'h0, 1'b1, 1'b1, 4'h0, MEMEN);
    step("lim_loadir", 16'h0, 1'b1, 1'b1, 4'h0, IRLD | PCINC);
    step("lim_dec", 16'h0, 1'b1, 1'b1, 4'h0, NONE);

    fl(16'h2205);
    step("ldto_dec", 16'h2205, 1'b0, 1'b1, 4'h0, MEMEN | adr(2));
    for (int i = 0; i <= WL; i++) step("ldto_wait", 16'h2205, 1'b0, 1'b1, 4'h0, MEMEN | adr(2));
    m_code = 2'd3;
    for (int i = 0; i < 2; i++) step("fault_ldto", 16'h2205, 1'b1, 1'b1, 4'h0, FLT);

    do_reset();
    fl(16'hF000);
    step("hlt_dec", 16'hF000, 1'b1, 1'b1, 4'h0, NONE);
    for (int i = 0; i < 3; i++) step("halt", 16'hF000, 1'b1, 1'b1, 4'h0, HLT);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
